// File: rtl/oled_pixel_streamer.sv
// Frame scanner + SPI mode-0 serializer: walks x/y over the panel in raster order,
// latches the RGB565 pixel the screen generator returns and shifts it out MSB first.
module oled_pixel_streamer #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] oled_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic        busy,
  output logic        frame_done,
  output logic        cs_n,
  output logic        dc,
  output logic        sclk,
  output logic        mosi
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_NEXT, S_DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] X_LAST   = 7'(WIDTH - 1);
  localparam logic [5:0] Y_LAST   = 6'(HEIGHT - 1);

  state_t      state_q, state_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic        busy_q, busy_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        div_tc;

  assign div_tc = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    busy_d    = busy_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        if (start) begin
          state_d = S_LOAD;
          x_d     = '0;
          y_d     = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
        end
      end
      S_LOAD: begin
        state_d   = S_SHIFT;
        shreg_d   = oled_data;
        bit_cnt_d = 4'd15;
        div_cnt_d = '0;
        cs_n_d    = 1'b0;
        busy_d    = 1'b1;
        sclk_d    = 1'b0;
      end
      S_SHIFT: begin
        if (div_tc) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          // Falling edge: the panel sampled the current bit on the rising edge.
          if (sclk_q) begin
            shreg_d   = {shreg_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
            if (bit_cnt_q == 4'd0) state_d = S_NEXT;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_NEXT: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            state_d = S_DONE;
          end else begin
            y_d     = y_q + 6'd1;
            state_d = S_LOAD;
          end
        end else begin
          x_d     = x_q + 7'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x          = x_q;
    y          = y_q;
    busy       = busy_q;
    cs_n       = cs_n_q;
    sclk       = sclk_q;
    dc         = 1'b1;
    frame_done = (state_q == S_DONE);
    mosi       = (state_q == S_SHIFT) && shreg_q[15];
  end

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench: dut_a (CLK_DIV=2, full panel) checks first-pixel timing and async reset;
// dut_b (CLK_DIV=1, 96x3) runs whole frames against a pixel scoreboard.
module tb_oled_pixel_streamer;
  localparam int W = 96, H = 3, N = W * H, P = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, start_a, start_b;
  logic [15:0] od_a, od_b;
  logic [6:0]  x_a, x_b;
  logic [5:0]  y_a, y_b;
  logic busy_a, fd_a, cs_n_a, dc_a, sclk_a, mosi_a;
  logic busy_b, fd_b, cs_n_b, dc_b, sclk_b, mosi_b;

  assign od_a = 16'hA5C3;
  // Generator output depends on x/y; garbage while sclk is high must never reach the wire.
  assign od_b = {x_b, y_b, 3'b101} ^ {16{sclk_b}};

  oled_pixel_streamer #(.CLK_DIV(2), .WIDTH(96), .HEIGHT(64)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .oled_data(od_a), .x(x_a), .y(y_a),
    .busy(busy_a), .frame_done(fd_a), .cs_n(cs_n_a), .dc(dc_a), .sclk(sclk_a), .mosi(mosi_a));

  oled_pixel_streamer #(.CLK_DIV(1), .WIDTH(W), .HEIGHT(H)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .oled_data(od_b), .x(x_b), .y(y_b),
    .busy(busy_b), .frame_done(fd_b), .cs_n(cs_n_b), .dc(dc_b), .sclk(sclk_b), .mosi(mosi_b));

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [15:0] q[$];
  logic [15:0] word_b, word_a, exp_w;
  int bits_b = 0, bits_a = 0, rises_b = 0, done_cnt = 0, cs_err = 0;
  logic prev_b = 1'b0, prev_a = 1'b0;

  always @(negedge clk) begin
    if (rst_b) begin
      bits_b = 0;
      prev_b = 1'b0;
    end else begin
      if (sclk_b && !prev_b) begin
        word_b = {word_b[14:0], mosi_b};
        bits_b++;
        rises_b++;
        if (bits_b == 16) begin
          bits_b = 0;
          if (q.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            exp_w = q.pop_front();
            chk("pixel_word", word_b, exp_w);
          end
        end
      end
      prev_b = sclk_b;
      if (fd_b) done_cnt++;
      if (busy_b == cs_n_b) cs_err++;
    end
    if (!rst_a && bits_a < 16 && sclk_a && !prev_a) begin
      word_a = {word_a[14:0], mosi_a};
      bits_a++;
      if (bits_a == 16) chk("a_first_word", word_a, 16'hA5C3);
    end
    prev_a = sclk_a;
  end

  task automatic push_frame();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        q.push_back({7'(xx), 6'(yy), 3'b101});
  endtask

  task automatic start_frame(output int t0);
    push_frame();
    @(posedge clk); #1;
    start_b = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_xy(input int wx, input int wy, output int t);
    int n = 0;
    t = 0;
    while (!(x_b == wx && y_b == wy)) begin
      @(posedge clk); #1;
      n++;
      if (n > 20000) begin
        chk("wait_xy_timeout", 1, 0);
        return;
      end
    end
    t = cyc;
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    t = 0;
    while (fd_b !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n > 12000) begin
        chk("wait_done_timeout", 1, 0);
        return;
      end
    end
    t = cyc;
  endtask

  typedef struct {
    int k;
    logic [6:0] x;
    logic cs_n, sclk, busy, mosi;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int base, t0, t1, t2, t3, r0;
    tbl[0] = '{1,  7'd0, 1'b0, 1'b0, 1'b1, 1'b0};  // LOAD
    tbl[1] = '{2,  7'd0, 1'b0, 1'b0, 1'b1, 1'b1};  // SHIFT, bit15 presented
    tbl[2] = '{4,  7'd0, 1'b0, 1'b1, 1'b1, 1'b1};  // first rising edge
    tbl[3] = '{5,  7'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{6,  7'd0, 1'b0, 1'b0, 1'b1, 1'b0};  // bit14
    tbl[5] = '{65, 7'd0, 1'b0, 1'b1, 1'b1, 1'b1};  // bit0 high phase
    tbl[6] = '{66, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0};  // NEXT
    tbl[7] = '{67, 7'd1, 1'b0, 1'b0, 1'b1, 1'b0};  // LOAD of x=1
    tbl[8] = '{69, 7'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{70, 7'd1, 1'b0, 1'b1, 1'b1, 1'b1};

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    #3;
    chk("rst_x", x_b, 0);       chk("rst_y", y_b, 0);
    chk("rst_cs_n", cs_n_b, 1); chk("rst_sclk", sclk_b, 0);
    chk("rst_mosi", mosi_b, 0); chk("rst_busy", busy_b, 0);
    chk("rst_fd", fd_b, 0);     chk("rst_dc", dc_b, 1);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    chk("idle_cs_n", cs_n_b, 1);

    // First pixel on dut_a
    start_a = 1'b1;
    base = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      while (cyc < base + tbl[i].k) begin
        @(posedge clk); #1;
      end
      chk($sformatf("a_x@%0d", tbl[i].k), x_a, tbl[i].x);
      chk($sformatf("a_cs_n@%0d", tbl[i].k), cs_n_a, tbl[i].cs_n);
      chk($sformatf("a_sclk@%0d", tbl[i].k), sclk_a, tbl[i].sclk);
      chk($sformatf("a_busy@%0d", tbl[i].k), busy_a, tbl[i].busy);
      chk($sformatf("a_mosi@%0d", tbl[i].k), mosi_a, tbl[i].mosi);
    end
    // Async reset mid-cycle while sclk is high
    #2 rst_a = 1'b1;
    #1;
    chk("a_rst_x", x_a, 0);         chk("a_rst_y", y_a, 0);
    chk("a_rst_cs_n", cs_n_a, 1);   chk("a_rst_sclk", sclk_a, 0);
    chk("a_rst_mosi", mosi_a, 0);   chk("a_rst_busy", busy_a, 0);
    chk("a_rst_fd", fd_a, 0);
    chk("a_word_seen", bits_a, 16);

    // Frame 1: row wrap spacing, edge count, timing
    r0 = rises_b;
    start_frame(t0);
    wait_xy(94, 0, t1);
    wait_xy(95, 0, t2);
    wait_xy(0, 1, t3);
    chk("pix_spacing", t2 - t1, P);
    chk("wrap_spacing", t3 - t2, P);
    chk("wrap_cs_n", cs_n_b, 0);
    wait_done(t1);
    chk("frame1_len", t1 - t0, 1 + N * P);
    chk("frame1_rises", rises_b - r0, N * 16);
    chk("done_busy_hi", busy_b, 1);
    @(posedge clk); #1;
    chk("post_cs_n", cs_n_b, 1);
    chk("post_busy", busy_b, 0);
    chk("post_fd", fd_b, 0);

    // Frame 2: start pulse mid-frame is ignored
    start_frame(t0);
    wait_xy(10, 0, t1);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_done(t1);
    chk("frame2_len", t1 - t0, 1 + N * P);

    // Reset during SHIFT of pixel (5,2), then full restart
    @(posedge clk); #1;
    start_frame(t0);
    wait_xy(5, 2, t1);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_cs_n", cs_n_b, 0);
    #2 rst_b = 1'b1;
    #1;
    chk("mid_rst_cs_n", cs_n_b, 1);
    chk("mid_rst_sclk", sclk_b, 0);
    chk("mid_rst_x", x_b, 0);
    chk("mid_rst_y", y_b, 0);
    chk("mid_rst_busy", busy_b, 0);
    q.delete();
    @(posedge clk); #1;
    rst_b = 1'b0;
    start_frame(t0);
    chk("restart_x", x_b, 0);
    chk("restart_y", y_b, 0);
    wait_done(t1);
    chk("restart_len", t1 - t0, 1 + N * P);

    // Back-to-back frames with start held high
    @(posedge clk); #1;
    push_frame();
    push_frame();
    start_b = 1'b1;
    t0 = cyc;
    wait_done(t1);
    chk("b2b_len1", t1 - t0, 1 + N * P);
    @(posedge clk); #1;
    chk("b2b_gap_cs_n", cs_n_b, 1);
    @(posedge clk); #1;
    chk("b2b_reload_cs_n", cs_n_b, 0);
    start_b = 1'b0;
    wait_done(t2);
    chk("b2b_len2", t2 - t1, 2 + N * P);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", q.size(), 0);
    chk("partial_bits", bits_b, 0);
    chk("done_pulses", done_cnt, 5);
    chk("cs_busy_mismatch", cs_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
